// File: rtl/decode_regfile_if.sv
// Decode/register-file bus for the Y86-64 SEQ datapath: decode inputs,
// writeback values and the resulting source/destination IDs and operands.
interface decode_regfile_if #(
  parameter int DATA_W = 64
);
  logic [3:0]        icode;
  logic [3:0]        rA;
  logic [3:0]        rB;
  logic              cnd;
  logic [DATA_W-1:0] valE;
  logic [DATA_W-1:0] valM;
  logic              wb_en;
  logic [DATA_W-1:0] valA;
  logic [DATA_W-1:0] valB;
  logic [3:0]        srcA;
  logic [3:0]        srcB;
  logic [3:0]        dstE;
  logic [3:0]        dstM;
  logic [3:0]        dbg_idx;
  logic [DATA_W-1:0] dbg_val;

  modport master (
    output icode, rA, rB, cnd, valE, valM, wb_en, dbg_idx,
    input  valA, valB, srcA, srcB, dstE, dstM, dbg_val
  );

  modport slave (
    input  icode, rA, rB, cnd, valE, valM, wb_en, dbg_idx,
    output valA, valB, srcA, srcB, dstE, dstM, dbg_val
  );
endinterface

// File: rtl/decode_regfile.sv
// Y86-64 SEQ decode stage plus 15-entry architectural register file.
// Combinational decode and reads; writeback commits on the rising edge.
module decode_regfile #(
  parameter int DATA_W = 64,
  parameter int NREG   = 15,
  parameter int RSP_ID = 4
) (
  input  logic            clk,
  input  logic            reset,
  decode_regfile_if.slave bus
);
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'(RSP_ID);

  logic [3:0] src_a;
  logic [3:0] src_b;
  logic [3:0] dst_e;
  logic [3:0] dst_m;

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (bus.icode)
      4'h2: begin
        src_a = bus.rA;
        dst_e = bus.cnd ? bus.rB : RNONE;
      end
      4'h3: dst_e = bus.rB;
      4'h4: begin
        src_a = bus.rA;
        src_b = bus.rB;
      end
      4'h5: begin
        src_b = bus.rB;
        dst_m = bus.rA;
      end
      4'h6: begin
        src_a = bus.rA;
        src_b = bus.rB;
        dst_e = bus.rB;
      end
      4'h8: begin
        src_b = RSP;
        dst_e = RSP;
      end
      4'h9: begin
        src_a = RSP;
        src_b = RSP;
        dst_e = RSP;
      end
      4'hA: begin
        src_a = bus.rA;
        src_b = RSP;
        dst_e = RSP;
      end
      4'hB: begin
        src_a = RSP;
        src_b = RSP;
        dst_e = RSP;
        dst_m = bus.rA;
      end
      default: ;
    endcase
  end

  assign bus.srcA = src_a;
  assign bus.srcB = src_b;
  assign bus.dstE = dst_e;
  assign bus.dstM = dst_m;

  logic [DATA_W-1:0] reg_file [NREG];
  logic [DATA_W-1:0] rd_arr   [16];

  genvar gi;
  generate
    // valM is checked first so popq %rsp leaves the popped value in %rsp.
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          reg_file[gi] <= '0;
        end else if (bus.wb_en && dst_m == 4'(gi)) begin
          reg_file[gi] <= bus.valM;
        end else if (bus.wb_en && dst_e == 4'(gi)) begin
          reg_file[gi] <= bus.valE;
        end
      end
    end

    // IDs at or above NREG (including RNONE) read as zero.
    for (gi = 0; gi < 16; gi++) begin : g_rd
      if (gi < NREG) begin : g_live
        assign rd_arr[gi] = reg_file[gi];
      end else begin : g_none
        assign rd_arr[gi] = '0;
      end
    end
  endgenerate

  assign bus.valA    = rd_arr[src_a];
  assign bus.valB    = rd_arr[src_b];
  assign bus.dbg_val = rd_arr[bus.dbg_idx];
endmodule

// File: doc/decode_regfile.md
Name: decode_regfile

Overview:
- Y86-64 SEQ register-file-plus-decode block; the read side of the writeback path.
- Decodes icode/rA/rB/cnd into source IDs (srcA, srcB) and destination IDs (dstE, dstM).
- Drives valA/valB to the execute and memory stages.
- On each clock edge, commits valE/valM into the 15-entry architectural register file.

Parameters:
- DATA_W, 64, register width in bits
- NREG, 15, number of architectural registers (IDs 0..14); ID 0xF = RNONE
- RSP_ID, 4, register ID of %rsp

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all registers
- icode  input  4  instruction code from fetch
- rA  input  4  register specifier A
- rB  input  4  register specifier B
- cnd  input  1  condition result from execute (cmovxx qualifier)
- valE  input  DATA_W  ALU result to commit
- valM  input  DATA_W  memory read value to commit
- wb_en  input  1  instruction retires this cycle; gates all writes
- valA  output  DATA_W  value of R[srcA], 0 if srcA = 0xF
- valB  output  DATA_W  value of R[srcB], 0 if srcB = 0xF
- srcA, srcB, dstE, dstM  output  4 each  decoded register IDs (0xF = none)
- dbg_idx  input  4  debug read index
- dbg_val  output  DATA_W  R[dbg_idx], 0 if dbg_idx >= NREG

Behaviour:
- Reset: asynchronous, active-high. All 15 registers go to 0 immediately, so valA/valB/dbg_val read 0 while reset is held. Reset asserted mid-write: reset wins and the write is dropped.
- Decode (combinational, independent of clk):
  - srcA = rA for icode 2 (rrmov/cmov), 4 (rmmov), 6 (OPq), A (push); RSP_ID for 9 (ret), B (pop); else 0xF.
  - srcB = rB for 4, 5 (mrmov), 6; RSP_ID for 8 (call), 9, A, B; else 0xF.
  - dstE = (cnd ? rB : 0xF) for 2; rB for 3 (irmov), 6; RSP_ID for 8, 9, A, B; else 0xF.
  - dstM = rA for 5, B; else 0xF.
  - Undefined icodes (0, 1, 7, C-F) give all four IDs = 0xF.
- Read: valA, valB and dbg_val are combinational reads of the current register contents.
  - No write-through bypass: a read in the same cycle as a write to that register returns the old value.
  - The new value is visible after the rising edge.
- Write (rising edge, only when wb_en=1 and reset=0):
  - R[dstE] <= valE if dstE != 0xF.
  - R[dstM] <= valM if dstM != 0xF.
  - dstE == dstM (popq %rsp): valM wins and valE is discarded.
  - IDs of 0xF are ignored; no register changes.
  - wb_en=0: no register changes, decode outputs still valid.
- Latency: decode and read outputs in 0 cycles; write commit in 1 cycle.
- Width: values are stored and passed unmodified at DATA_W bits; no extension or truncation.

Test Plan:
- Reset: assert reset, then check dbg_val = 0 for idx 0..14 and for idx 15. Preload R3, assert reset asynchronously mid-cycle, and check R3 clears before the next edge.
- irmovq: icode=3, rB=2, valE=0x123456789ABCDEF0, wb_en=1, one edge -> dstE=2, dstM=F; dbg_idx=2 reads 0x123456789ABCDEF0. During that same cycle, a read via srcB (icode=6, rB=2) still returns the old value 0.
- OPq: preload R1=5, R2=7; icode=6, rA=1, rB=2 -> valA=5, valB=7, srcA=1, srcB=2. Commit valE=12 -> R2=12.
- cmovxx: icode=2, rA=0, rB=6, cnd=0, wb_en=1, valE=0xFF -> dstE=F, R6 unchanged. Repeat with cnd=1 -> R6=0xFF.
- popq %rsp: R4=0x100; icode=B, rA=4, valE=0x108, valM=0xAA -> srcA=srcB=4, valA=valB=0x100; after the edge R4=0xAA (valM wins).
- Write gating: icode=5, rA=9, valM=0x55, wb_en=0 -> R9 unchanged. Then icode=0 with wb_en=1 -> all IDs F, no register changes.
